// File: rtl/demux_lane_collector_pkg.sv
// Shared constants and the round-robin grant function for the demux lane collector.
package demux_collector_pkg;

    localparam int NLANES     = 8;
    localparam int LANE_IDX_W = 3;

    // First pending lane at or after rr_ptr, in circular order.
    // Returns rr_ptr when nothing is pending.
    function automatic logic [LANE_IDX_W-1:0] next_rr(
        input logic [NLANES-1:0]     pending,
        input logic [LANE_IDX_W-1:0] rr_ptr
    );
        logic [LANE_IDX_W-1:0] idx;
        logic [LANE_IDX_W-1:0] grant;
        logic                  found;
        grant = rr_ptr;
        found = 1'b0;
        for (int i = 0; i < NLANES; i++) begin
            idx = rr_ptr + LANE_IDX_W'(i);
            if (!found && pending[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/demux_lane_collector_if.sv
// Output word stream of the demux lane collector: valid/ready handshake tagged with lane index.
interface demux_lane_collector_if #(
    parameter int WORD_W = 8
) ();
    import demux_collector_pkg::*;

    logic [WORD_W-1:0]     out_data;
    logic [LANE_IDX_W-1:0] out_lane;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_perr;

    modport master (
        output out_data,
        output out_lane,
        output out_valid,
        output out_perr,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_lane,
        input  out_valid,
        input  out_perr,
        output out_ready
    );

endinterface

// File: rtl/demux_lane_collector_lane_deser.sv
// One collector lane: LSB-first deserialiser, bit counter, one-deep pending word and sticky overflow.
module lane_deser #(
    parameter int NBITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cap,
    input  logic             bit_in,
    input  logic             grant,
    output logic             pending,
    output logic [NBITS-1:0] word,
    output logic             ovf
);

    localparam int CNT_W = $clog2(NBITS + 1);

    logic [NBITS-1:0] shift_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [NBITS-1:0] word_reg;
    logic             pending_reg;
    logic             ovf_reg;
    logic [NBITS-1:0] shifted;
    logic             last_bit;

    // New bits enter at the MSB so the first bit received ends up in bit 0.
    assign shifted  = {bit_in, shift_reg[NBITS-1:1]};
    assign last_bit = (cnt_reg == CNT_W'(NBITS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg   <= '0;
            cnt_reg     <= '0;
            word_reg    <= '0;
            pending_reg <= 1'b0;
            ovf_reg     <= 1'b0;
        end else begin
            if (grant) begin
                pending_reg <= 1'b0;
            end
            if (cap) begin
                shift_reg <= shifted;
                if (last_bit) begin
                    cnt_reg <= '0;
                    // A grant this cycle frees the slot, so the new word replaces it.
                    if (pending_reg && !grant) begin
                        ovf_reg <= 1'b1;
                    end else begin
                        word_reg    <= shifted;
                        pending_reg <= 1'b1;
                    end
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end
    end

    assign pending = pending_reg;
    assign word    = word_reg;
    assign ovf     = ovf_reg;

endmodule

// File: rtl/demux_lane_collector.sv
// Collects demuxed bits into per-lane words and drains them round-robin onto one output stream.
// Optional feature: define LANE_PARITY_EN to append an even-parity bit to every lane word.
module demux_lane_collector
    import demux_collector_pkg::*;
#(
    parameter int WORD_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NLANES-1:0]       d,
    input  logic [LANE_IDX_W-1:0]   sel,
    input  logic                    bit_vld,
    output logic [NLANES-1:0]       ovf,
    demux_lane_collector_if.master  out
);

`ifdef LANE_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int NBITS = WORD_W + PAR_W;

    logic [NLANES-1:0]     pending_vec;
    logic [NLANES-1:0]     grant_vec;
    logic [NBITS-1:0]      lane_word [NLANES];
    logic [NBITS-1:0]      sel_word;
    logic [LANE_IDX_W-1:0] grant_idx;
    logic                  any_pending;
    logic                  load;
    logic                  sel_perr;

    logic [WORD_W-1:0]     out_data_reg;
    logic [LANE_IDX_W-1:0] out_lane_reg;
    logic                  out_valid_reg;
    logic                  out_perr_reg;
    logic [LANE_IDX_W-1:0] rr_ptr_reg;

    generate
        for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
            lane_deser #(
                .NBITS (NBITS)
            ) u_lane (
                .clk     (clk),
                .rst     (rst),
                .cap     (bit_vld && (sel == LANE_IDX_W'(gi))),
                .bit_in  (d[gi]),
                .grant   (grant_vec[gi]),
                .pending (pending_vec[gi]),
                .word    (lane_word[gi]),
                .ovf     (ovf[gi])
            );
        end
    endgenerate

    // The output register is free when empty or being handed off this cycle.
    assign load        = !out_valid_reg || out.out_ready;
    assign any_pending = |pending_vec;
    assign grant_idx   = next_rr(pending_vec, rr_ptr_reg);
    assign grant_vec   = (load && any_pending) ? (NLANES'(1) << grant_idx) : '0;
    assign sel_word    = lane_word[grant_idx];

`ifdef LANE_PARITY_EN
    // Even parity: XOR across data plus parity bit must be zero.
    assign sel_perr = ^sel_word;
`else
    assign sel_perr = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_reg  <= '0;
            out_lane_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_perr_reg  <= 1'b0;
            rr_ptr_reg    <= '0;
        end else if (load) begin
            if (any_pending) begin
                out_data_reg  <= sel_word[WORD_W-1:0];
                out_lane_reg  <= grant_idx;
                out_valid_reg <= 1'b1;
                out_perr_reg  <= sel_perr;
                rr_ptr_reg    <= grant_idx + LANE_IDX_W'(1);
            end else begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out.out_data  = out_data_reg;
    assign out.out_lane  = out_lane_reg;
    assign out.out_valid = out_valid_reg;
    assign out.out_perr  = out_perr_reg;

endmodule

// File: tb/tb_demux_lane_collector.sv
// Directed self-checking bench for demux_lane_collector (default WORD_W=8, parity optional).
module tb_demux_lane_collector;

    localparam int WORD_W = 8;
`ifdef LANE_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] d = '0;
    logic [2:0] sel = '0;
    logic       bit_vld = 1'b0;
    logic [7:0] ovf;

    int checks = 0;
    int errors = 0;

    demux_lane_collector_if #(.WORD_W(WORD_W)) bus ();

    demux_lane_collector #(.WORD_W(WORD_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .d       (d),
        .sel     (sel),
        .bit_vld (bit_vld),
        .ovf     (ovf),
        .out     (bus.master)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bit_vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Sends one word LSB-first into a lane with random noise on the other demux outputs.
    task automatic send_word(input int lane, input logic [7:0] value, input logic par);
        for (int i = 0; i < WORD_W; i++) begin
            @(negedge clk);
            bit_vld = 1'b1;
            sel = 3'(lane);
            d = 8'($urandom);
            d[lane] = value[i];
        end
        if (PAR_ON) begin
            @(negedge clk);
            d = 8'($urandom);
            d[lane] = par;
        end
        @(negedge clk);
        bit_vld = 1'b0;
        d = 8'($urandom);
        $display("send lane %0d value %h", lane, value);
    endtask

    // Waits (bounded) for a valid word with out_ready already high and consumes it.
    task automatic pop_word(output logic [7:0] data, output logic [2:0] lane,
                            output logic perr, output bit ok);
        for (int k = 0; k < 30 && !bus.out_valid; k++) @(negedge clk);
        ok   = bus.out_valid;
        data = bus.out_data;
        lane = bus.out_lane;
        perr = bus.out_perr;
        if (ok) @(negedge clk);
        $display("pop ok %0d lane %0d data %h perr %0b", ok, lane, data, perr);
    endtask

    task automatic test_reset();
        bus.out_ready = 1'b0;
        do_reset();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.out_valid); end
        checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", bus.out_data); end
        checks++; if (bus.out_lane !== 3'd0) begin errors++; $display("FAIL reset_lane got %0d exp 0", bus.out_lane); end
        checks++; if (ovf !== 8'h00) begin errors++; $display("FAIL reset_ovf got %h exp 00", ovf); end
        checks++; if (bus.out_perr !== 1'b0) begin errors++; $display("FAIL reset_perr got %b exp 0", bus.out_perr); end
    endtask

    task automatic test_basic();
        do_reset();
        bus.out_ready = 1'b1;
        send_word(3, 8'h4D, ^8'h4D);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_latency got valid %b exp 0", bus.out_valid); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", bus.out_valid); end
        checks++; if (bus.out_data !== 8'h4D) begin errors++; $display("FAIL basic_data got %h exp 4d", bus.out_data); end
        checks++; if (bus.out_lane !== 3'd3) begin errors++; $display("FAIL basic_lane got %0d exp 3", bus.out_lane); end
        checks++; if (bus.out_perr !== 1'b0) begin errors++; $display("FAIL basic_perr got %b exp 0", bus.out_perr); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse got valid %b exp 0", bus.out_valid); end
    endtask

    task automatic test_interleave();
        logic [7:0] data;
        logic [2:0] lane;
        logic       perr;
        bit         ok;
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < WORD_W + int'(PAR_ON); i++) begin
            @(negedge clk);
            bit_vld = 1'b1; sel = 3'd0; d = 8'($urandom); d[0] = 1'b1;
            @(negedge clk);
            sel = 3'd5; d = 8'($urandom); d[5] = 1'b0;
        end
        @(negedge clk);
        bit_vld = 1'b0;
        pop_word(data, lane, perr, ok);
        checks++; if (!ok || data !== 8'hFF || lane !== 3'd0) begin errors++; $display("FAIL ilv_first got ok %0d lane %0d data %h exp lane 0 data ff", ok, lane, data); end
        pop_word(data, lane, perr, ok);
        checks++; if (!ok || data !== 8'h00 || lane !== 3'd5) begin errors++; $display("FAIL ilv_second got ok %0d lane %0d data %h exp lane 5 data 00", ok, lane, data); end
        repeat (3) @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0 || ovf !== 8'h00) begin errors++; $display("FAIL ilv_idle got valid %b ovf %h exp 0 00", bus.out_valid, ovf); end
    endtask

    task automatic test_round_robin();
        logic [7:0] data;
        logic [2:0] lane;
        logic       perr;
        bit         ok;
        logic [2:0] exp_lane [7];
        logic [7:0] exp_data [7];
        exp_lane = '{3'd0, 3'd2, 3'd6, 3'd7, 3'd7, 3'd2, 3'd5};
        exp_data = '{8'h10, 8'h22, 8'h66, 8'h77, 8'h70, 8'h2A, 8'h55};
        do_reset();
        bus.out_ready = 1'b0;
        // Lane 0 occupies the output register; 7, 6, 2 then wait behind it.
        send_word(0, 8'h10, ^8'h10);
        send_word(7, 8'h77, ^8'h77);
        send_word(6, 8'h66, ^8'h66);
        send_word(2, 8'h22, ^8'h22);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pop_word(data, lane, perr, ok);
            checks++; if (!ok || lane !== exp_lane[i] || data !== exp_data[i]) begin errors++; $display("FAIL rr1_%0d got ok %0d lane %0d data %h exp lane %0d data %h", i, ok, lane, data, exp_lane[i], exp_data[i]); end
        end
        bus.out_ready = 1'b0;
        // Pointer wrapped to 0 after lane 7, so lane 2 beats lane 5.
        send_word(7, 8'h70, ^8'h70);
        send_word(5, 8'h55, ^8'h55);
        send_word(2, 8'h2A, ^8'h2A);
        bus.out_ready = 1'b1;
        for (int i = 4; i < 7; i++) begin
            pop_word(data, lane, perr, ok);
            checks++; if (!ok || lane !== exp_lane[i] || data !== exp_data[i]) begin errors++; $display("FAIL rr2_%0d got ok %0d lane %0d data %h exp lane %0d data %h", i, ok, lane, data, exp_lane[i], exp_data[i]); end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] data;
        logic [2:0] lane;
        logic       perr;
        bit         ok;
        do_reset();
        bus.out_ready = 1'b0;
        send_word(1, 8'hA5, ^8'hA5);
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5) begin errors++; $display("FAIL ovf_hold1 got valid %b data %h exp 1 a5", bus.out_valid, bus.out_data); end
        send_word(1, 8'h3C, ^8'h3C);
        checks++; if (bus.out_data !== 8'hA5 || ovf !== 8'h00) begin errors++; $display("FAIL ovf_hold2 got data %h ovf %h exp a5 00", bus.out_data, ovf); end
        send_word(1, 8'h11, ^8'h11);
        checks++; if (ovf !== 8'h02) begin errors++; $display("FAIL ovf_flag got %h exp 02", ovf); end
        checks++; if (bus.out_data !== 8'hA5 || bus.out_lane !== 3'd1) begin errors++; $display("FAIL ovf_stable got data %h lane %0d exp a5 1", bus.out_data, bus.out_lane); end
        bus.out_ready = 1'b1;
        pop_word(data, lane, perr, ok);
        checks++; if (!ok || data !== 8'hA5) begin errors++; $display("FAIL ovf_pop1 got ok %0d data %h exp a5", ok, data); end
        pop_word(data, lane, perr, ok);
        checks++; if (!ok || data !== 8'h3C) begin errors++; $display("FAIL ovf_pop2 got ok %0d data %h exp 3c", ok, data); end
        repeat (3) @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0 || ovf !== 8'h02) begin errors++; $display("FAIL ovf_drop got valid %b ovf %h exp 0 02", bus.out_valid, ovf); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] data;
        logic [2:0] lane;
        logic       perr;
        bit         ok;
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bit_vld = 1'b1; sel = 3'd4; d = 8'($urandom);
        end
        @(negedge clk);
        bit_vld = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (ovf !== 8'h00 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_state got ovf %h valid %b exp 00 0", ovf, bus.out_valid); end
        send_word(4, 8'h81, ^8'h81);
        pop_word(data, lane, perr, ok);
        checks++; if (!ok || data !== 8'h81 || lane !== 3'd4) begin errors++; $display("FAIL rstmid_word got ok %0d lane %0d data %h exp lane 4 data 81", ok, lane, data); end
        repeat (4) @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_extra got valid %b exp 0", bus.out_valid); end
    endtask

    task automatic test_parity();
        logic [7:0] data;
        logic [2:0] lane;
        logic       perr;
        bit         ok;
        do_reset();
        bus.out_ready = 1'b1;
        if (PAR_ON) begin
            send_word(0, 8'h03, 1'b1);
            pop_word(data, lane, perr, ok);
            checks++; if (!ok || data !== 8'h03 || perr !== 1'b1) begin errors++; $display("FAIL par_bad got ok %0d data %h perr %b exp 03 1", ok, data, perr); end
            send_word(0, 8'h03, 1'b0);
            pop_word(data, lane, perr, ok);
            checks++; if (!ok || data !== 8'h03 || perr !== 1'b0) begin errors++; $display("FAIL par_good got ok %0d data %h perr %b exp 03 0", ok, data, perr); end
        end else begin
            send_word(0, 8'h03, 1'b1);
            pop_word(data, lane, perr, ok);
            checks++; if (!ok || data !== 8'h03 || perr !== 1'b0) begin errors++; $display("FAIL par_off got ok %0d data %h perr %b exp 03 0", ok, data, perr); end
        end
    endtask

    initial begin
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_interleave();
        test_round_robin();
        test_overflow();
        test_reset_mid();
        test_parity();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
